// File: rtl/uc_ciclo_medicao_pkg.sv
// Shared definitions for the level-monitor control unit: state codes
// (also visible on db_estado) and the classification codes produced by
// the datapath classifier.
package uc_ciclo_medicao_pkg;

    localparam logic [3:0] ST_INICIAL         = 4'd0;
    localparam logic [3:0] ST_PREPARA         = 4'd1;
    localparam logic [3:0] ST_ESPERA_1S       = 4'd2;
    localparam logic [3:0] ST_MEDE            = 4'd3;
    localparam logic [3:0] ST_AGUARDA_MEDIDA  = 4'd4;
    localparam logic [3:0] ST_CLASSIFICA      = 4'd5;
    localparam logic [3:0] ST_AGUARDA_CLASS   = 4'd6;
    localparam logic [3:0] ST_TRANSMITE       = 4'd7;
    localparam logic [3:0] ST_AGUARDA_CARATER = 4'd8;
    localparam logic [3:0] ST_PROX_CARATER    = 4'd9;
    localparam logic [3:0] ST_ATUA            = 4'd10;
    localparam logic [3:0] ST_ESPERA_2S       = 4'd11;
    localparam logic [3:0] ST_DESLIGA         = 4'd12;
    localparam logic [3:0] ST_FALHA           = 4'd13;

    localparam logic [2:0] CLASSE_NORMAL  = 3'd0;
    localparam logic [2:0] CLASSE_BAIXO   = 3'd1;
    localparam logic [2:0] CLASSE_CRITICO = 3'd2;
    localparam logic [2:0] CLASSE_ALTO    = 3'd3;

    // Codes outside the defined set are handled as a normal level.
    function automatic logic [2:0] normaliza_classe(input logic [2:0] medida);
        if (medida > CLASSE_ALTO) begin
            return CLASSE_NORMAL;
        end
        return medida;
    endfunction

endpackage

// File: rtl/uc_ciclo_medicao_watchdog.sv
// Measurement watchdog for uc_ciclo_medicao. Only compiled when
// UC_WATCHDOG_MEDIDA_EN is defined.
// The counter is cleared by 'clear', counts while 'enable' is high and
// flags 'expired' once it holds TIMEOUT_CICLOS-1.
`ifdef UC_WATCHDOG_MEDIDA_EN
module uc_ciclo_medicao_watchdog #(
    parameter int TIMEOUT_CICLOS = 3000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [21:0] LIMITE = 22'(TIMEOUT_CICLOS - 1);

    logic [21:0] contagem;

    // Cycle counter; holds at the limit so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable && (contagem != LIMITE)) begin
            contagem <= contagem + 22'd1;
        end
    end

    assign expired = enable && (contagem == LIMITE);

endmodule
`endif

// File: rtl/uc_ciclo_medicao.sv
// Control unit for the level monitor: wait, measure, classify, send the
// 4-character frame, then drive buzzers and valve. Discarded measurements
// are retried; MAX_TENTATIVAS consecutive discards lead to FALHA.
// Optional: UC_WATCHDOG_MEDIDA_EN adds a timeout in AGUARDA_MEDIDA that
// behaves like a discarded measurement.
// All outputs are decoded from registered state (plus the FALHA entry flag).
module uc_ciclo_medicao
    import uc_ciclo_medicao_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3
`ifdef UC_WATCHDOG_MEDIDA_EN
    ,
    parameter int TIMEOUT_CICLOS = 3000000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       fim_1s,
    input  logic       fim_2s,
    input  logic       fim_estado4,
    input  logic       fim_medida,
    input  logic       fim_classificacao,
    input  logic [2:0] medida_classificacao,
    input  logic       descartar_medida,
    input  logic       fim_carater,
    input  logic       fim_mensagem,
    output logic       zera,
    output logic       conta_1s,
    output logic       conta_2s,
    output logic       conta_estado4,
    output logic       mensurar,
    output logic       analisa_medida,
    output logic       envia,
    output logic       muda,
    output logic       liga_buzzer_alta,
    output logic       liga_buzzer_baixa,
    output logic       desliga_buzzers,
    output logic       abre_valvula_auto,
    output logic       fecha_valvula_auto,
    output logic [3:0] db_estado,
    output logic [3:0] db_tentativas
);

    localparam logic [3:0] MAX_T = 4'(MAX_TENTATIVAS);

    logic [3:0] estado, proximo;
    logic [3:0] tentativas, tentativas_prox, tentativas_inc;
    logic [2:0] classe, classe_prox;
    logic       ultimo, ultimo_prox;
    logic       falha_entrada;
    logic       expirou;

`ifdef UC_WATCHDOG_MEDIDA_EN
    uc_ciclo_medicao_watchdog #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado == ST_MEDE),
        .enable (estado == ST_AGUARDA_MEDIDA),
        .expired(expirou)
    );
`else
    assign expirou = 1'b0;
`endif

    // Retry count after one more failure, saturating at the limit.
    assign tentativas_inc = (tentativas >= MAX_T) ? MAX_T : tentativas + 4'd1;

    // Next-state and next-counter logic.
    always_comb begin
        proximo         = estado;
        tentativas_prox = tentativas;
        classe_prox     = classe;
        ultimo_prox     = ultimo;
        case (estado)
            ST_INICIAL: begin
                if (ligar) begin
                    proximo         = ST_PREPARA;
                    tentativas_prox = '0;
                end
            end
            ST_PREPARA: begin
                tentativas_prox = '0;
                proximo         = ST_ESPERA_1S;
            end
            ST_ESPERA_1S: begin
                if (fim_1s) proximo = ST_MEDE;
            end
            ST_MEDE: begin
                proximo = ST_AGUARDA_MEDIDA;
            end
            ST_AGUARDA_MEDIDA: begin
                // A measurement arriving on the timeout cycle still counts.
                if (fim_medida) begin
                    proximo = ST_CLASSIFICA;
                end else if (expirou) begin
                    tentativas_prox = tentativas_inc;
                    proximo = (tentativas_inc == MAX_T) ? ST_FALHA : ST_ESPERA_1S;
                end
            end
            ST_CLASSIFICA: begin
                proximo = ST_AGUARDA_CLASS;
            end
            ST_AGUARDA_CLASS: begin
                if (fim_classificacao) begin
                    if (descartar_medida) begin
                        tentativas_prox = tentativas_inc;
                        proximo = (tentativas_inc == MAX_T) ? ST_FALHA : ST_ESPERA_1S;
                    end else begin
                        classe_prox     = normaliza_classe(medida_classificacao);
                        tentativas_prox = '0;
                        proximo         = ST_TRANSMITE;
                    end
                end
            end
            ST_TRANSMITE: begin
                proximo = ST_AGUARDA_CARATER;
            end
            ST_AGUARDA_CARATER: begin
                if (fim_carater) begin
                    ultimo_prox = fim_mensagem;
                    proximo     = ST_PROX_CARATER;
                end
            end
            ST_PROX_CARATER: begin
                proximo = ultimo ? ST_ATUA : ST_TRANSMITE;
            end
            ST_ATUA: begin
                proximo = ST_ESPERA_2S;
            end
            ST_ESPERA_2S: begin
                if (fim_2s) proximo = ligar ? ST_ESPERA_1S : ST_DESLIGA;
            end
            ST_DESLIGA: begin
                proximo = ST_INICIAL;
            end
            ST_FALHA: begin
                // The entry cycle is reserved for the alarm strobes.
                if (!falha_entrada && fim_estado4) begin
                    tentativas_prox = '0;
                    proximo         = ST_PREPARA;
                end
            end
            default: begin
                proximo = ST_INICIAL;
            end
        endcase
    end

    // State, counters and the FALHA entry flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= ST_INICIAL;
            tentativas    <= '0;
            classe        <= CLASSE_NORMAL;
            ultimo        <= 1'b0;
            falha_entrada <= 1'b0;
        end else begin
            estado        <= proximo;
            tentativas    <= tentativas_prox;
            classe        <= classe_prox;
            ultimo        <= ultimo_prox;
            falha_entrada <= (proximo == ST_FALHA) && (estado != ST_FALHA);
        end
    end

    // Moore output decode.
    always_comb begin
        zera               = 1'b0;
        conta_1s           = 1'b0;
        conta_2s           = 1'b0;
        conta_estado4      = 1'b0;
        mensurar           = 1'b0;
        analisa_medida     = 1'b0;
        envia              = 1'b0;
        muda               = 1'b0;
        liga_buzzer_alta   = 1'b0;
        liga_buzzer_baixa  = 1'b0;
        desliga_buzzers    = 1'b0;
        abre_valvula_auto  = 1'b0;
        fecha_valvula_auto = 1'b0;
        case (estado)
            ST_PREPARA:      zera = 1'b1;
            ST_ESPERA_1S:    conta_1s = 1'b1;
            ST_MEDE:         mensurar = 1'b1;
            ST_CLASSIFICA:   analisa_medida = 1'b1;
            ST_TRANSMITE:    envia = 1'b1;
            ST_PROX_CARATER: muda = 1'b1;
            ST_ATUA: begin
                case (classe)
                    CLASSE_CRITICO: begin
                        abre_valvula_auto = 1'b1;
                        liga_buzzer_baixa = 1'b1;
                    end
                    CLASSE_BAIXO: begin
                        liga_buzzer_baixa = 1'b1;
                    end
                    CLASSE_ALTO: begin
                        fecha_valvula_auto = 1'b1;
                        liga_buzzer_alta   = 1'b1;
                    end
                    default: begin
                        fecha_valvula_auto = 1'b1;
                        desliga_buzzers    = 1'b1;
                    end
                endcase
            end
            ST_ESPERA_2S:    conta_2s = 1'b1;
            ST_DESLIGA: begin
                desliga_buzzers    = 1'b1;
                fecha_valvula_auto = 1'b1;
            end
            ST_FALHA: begin
                if (falha_entrada) begin
                    liga_buzzer_alta   = 1'b1;
                    liga_buzzer_baixa  = 1'b1;
                    fecha_valvula_auto = 1'b1;
                end else begin
                    conta_estado4 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign db_estado     = estado;
    assign db_tentativas = tentativas;

endmodule

// File: tb/tb_uc_ciclo_medicao.sv
// Directed testbench for uc_ciclo_medicao: a table of per-cycle input
// records with expected state, retry count and output strobes, followed by
// hand-written sequences for FALHA, asynchronous reset and the measurement
// timeout.
module tb_uc_ciclo_medicao;

    localparam logic [12:0] O_NADA  = 13'h0000;
    localparam logic [12:0] O_ZERA  = 13'h1000;
    localparam logic [12:0] O_C1    = 13'h0800;
    localparam logic [12:0] O_C2    = 13'h0400;
    localparam logic [12:0] O_C4    = 13'h0200;
    localparam logic [12:0] O_MED   = 13'h0100;
    localparam logic [12:0] O_ANA   = 13'h0080;
    localparam logic [12:0] O_ENV   = 13'h0040;
    localparam logic [12:0] O_MUDA  = 13'h0020;
    localparam logic [12:0] O_BZA   = 13'h0010;
    localparam logic [12:0] O_BZB   = 13'h0008;
    localparam logic [12:0] O_DESL  = 13'h0004;
    localparam logic [12:0] O_ABRE  = 13'h0002;
    localparam logic [12:0] O_FECHA = 13'h0001;

    typedef struct {
        logic       ligar;
        logic       f1;
        logic       f2;
        logic       f4;
        logic       fmed;
        logic       fcls;
        logic [2:0] med;
        logic       desc;
        logic       fcar;
        logic       fmsg;
        logic [3:0] e_est;
        logic [3:0] e_tent;
        logic [12:0] e_out;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar, fim_1s, fim_2s, fim_estado4, fim_medida, fim_classificacao;
    logic [2:0] medida_classificacao;
    logic       descartar_medida, fim_carater, fim_mensagem;
    logic       zera, conta_1s, conta_2s, conta_estado4, mensurar, analisa_medida, envia, muda;
    logic       liga_buzzer_alta, liga_buzzer_baixa, desliga_buzzers, abre_valvula_auto, fecha_valvula_auto;
    logic [3:0] db_estado, db_tentativas;
    logic [12:0] outs;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    // Clock and reset
    always #5 clock = ~clock;

    uc_ciclo_medicao #(
        .MAX_TENTATIVAS(3)
`ifdef UC_WATCHDOG_MEDIDA_EN
        ,
        .TIMEOUT_CICLOS(16)
`endif
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .ligar                (ligar),
        .fim_1s               (fim_1s),
        .fim_2s               (fim_2s),
        .fim_estado4          (fim_estado4),
        .fim_medida           (fim_medida),
        .fim_classificacao    (fim_classificacao),
        .medida_classificacao (medida_classificacao),
        .descartar_medida     (descartar_medida),
        .fim_carater          (fim_carater),
        .fim_mensagem         (fim_mensagem),
        .zera                 (zera),
        .conta_1s             (conta_1s),
        .conta_2s             (conta_2s),
        .conta_estado4        (conta_estado4),
        .mensurar             (mensurar),
        .analisa_medida       (analisa_medida),
        .envia                (envia),
        .muda                 (muda),
        .liga_buzzer_alta     (liga_buzzer_alta),
        .liga_buzzer_baixa    (liga_buzzer_baixa),
        .desliga_buzzers      (desliga_buzzers),
        .abre_valvula_auto    (abre_valvula_auto),
        .fecha_valvula_auto   (fecha_valvula_auto),
        .db_estado            (db_estado),
        .db_tentativas        (db_tentativas)
    );

    assign outs = {zera, conta_1s, conta_2s, conta_estado4, mensurar, analisa_medida, envia, muda,
                   liga_buzzer_alta, liga_buzzer_baixa, desliga_buzzers, abre_valvula_auto, fecha_valvula_auto};

    // Driver tasks
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fim_1s = 0; fim_2s = 0; fim_estado4 = 0; fim_medida = 0; fim_classificacao = 0;
        medida_classificacao = 0; descartar_medida = 0; fim_carater = 0; fim_mensagem = 0;
    endtask

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
        end
    endtask

    task automatic add(input logic l, input logic f1, input logic f2, input logic f4, input logic fmed,
                       input logic fcls, input logic [2:0] med, input logic desc, input logic fcar,
                       input logic fmsg, input logic [3:0] est, input logic [3:0] tent, input logic [12:0] o);
        vec_t v;
        v.ligar = l; v.f1 = f1; v.f2 = f2; v.f4 = f4; v.fmed = fmed; v.fcls = fcls; v.med = med;
        v.desc = desc; v.fcar = fcar; v.fmsg = fmsg; v.e_est = est; v.e_tent = tent; v.e_out = o;
        vecs.push_back(v);
    endtask

    // From ESPERA_1S: run one measurement up to AGUARDA_CLASS.
    task automatic ate_classificacao();
        fim_1s = 1; cyc(); fim_1s = 0;
        cyc();
        fim_medida = 1; cyc(); fim_medida = 0;
        cyc();
    endtask

    task automatic descarta();
        fim_classificacao = 1; descartar_medida = 1; cyc();
        fim_classificacao = 0; descartar_medida = 0;
    endtask

    initial begin
        int n;
        reset = 1; ligar = 0;
        clear_inputs();

        // Table: CRITICO frame, two discards then ALTO, then out-of-range class with ligar dropped
        add(1,0,0,0,0,0,0,0,0,0, 4'd1, 0, O_ZERA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd2, 0, O_C1);
        add(1,0,0,0,0,0,0,0,0,0, 4'd2, 0, O_C1);
        add(1,1,0,0,0,0,0,0,0,0, 4'd3, 0, O_MED);
        add(1,0,0,0,0,0,0,0,0,0, 4'd4, 0, O_NADA);
        add(1,0,0,0,0,1,0,0,1,0, 4'd4, 0, O_NADA);
        add(1,0,1,0,0,0,0,0,0,0, 4'd4, 0, O_NADA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd4, 0, O_NADA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd4, 0, O_NADA);
        add(1,0,0,0,1,0,0,0,0,0, 4'd5, 0, O_ANA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd6, 0, O_NADA);
        add(1,0,0,0,0,1,3'd2,0,0,0, 4'd7, 0, O_ENV);
        for (int c = 0; c < 4; c++) begin
            add(1,(c == 0),0,0,0,0,0,0,0,0, 4'd8, 0, O_NADA);
            add(1,0,0,0,0,0,0,0,1,(c == 3), 4'd9, 0, O_MUDA);
            if (c < 3) add(1,0,0,0,0,0,0,0,0,0, 4'd7, 0, O_ENV);
        end
        add(1,0,0,0,0,0,0,0,0,0, 4'd10, 0, O_ABRE | O_BZB);
        add(1,0,0,0,0,0,0,0,0,0, 4'd11, 0, O_C2);
        add(1,0,0,0,0,0,0,0,0,0, 4'd11, 0, O_C2);
        add(1,0,1,0,0,0,0,0,0,0, 4'd2, 0, O_C1);
        for (int k = 1; k <= 2; k++) begin
            add(1,1,0,0,0,0,0,0,0,0, 4'd3, 4'(k-1), O_MED);
            add(1,0,0,0,0,0,0,0,0,0, 4'd4, 4'(k-1), O_NADA);
            add(1,0,0,0,1,0,0,0,0,0, 4'd5, 4'(k-1), O_ANA);
            add(1,0,0,0,0,0,0,0,0,0, 4'd6, 4'(k-1), O_NADA);
            add(1,0,0,0,0,1,0,1,0,0, 4'd2, 4'(k),   O_C1);
        end
        add(1,1,0,0,0,0,0,0,0,0, 4'd3, 2, O_MED);
        add(1,0,0,0,0,0,0,0,0,0, 4'd4, 2, O_NADA);
        add(1,0,0,0,1,0,0,0,0,0, 4'd5, 2, O_ANA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd6, 2, O_NADA);
        add(1,0,0,0,0,1,3'd3,0,0,0, 4'd7, 0, O_ENV);
        add(1,0,0,0,0,0,0,0,0,0, 4'd8, 0, O_NADA);
        add(1,0,0,0,0,0,0,0,1,1, 4'd9, 0, O_MUDA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd10, 0, O_FECHA | O_BZA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd11, 0, O_C2);
        add(0,0,1,0,0,0,0,0,0,0, 4'd12, 0, O_DESL | O_FECHA);
        add(0,0,0,0,0,0,0,0,0,0, 4'd0, 0, O_NADA);
        add(0,0,0,0,0,0,0,0,0,0, 4'd0, 0, O_NADA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd1, 0, O_ZERA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd2, 0, O_C1);
        add(1,1,0,0,0,0,0,0,0,0, 4'd3, 0, O_MED);
        add(1,0,0,0,0,0,0,0,0,0, 4'd4, 0, O_NADA);
        add(1,0,0,0,1,0,0,0,0,0, 4'd5, 0, O_ANA);
        add(1,0,0,0,0,0,0,0,0,0, 4'd6, 0, O_NADA);
        add(1,0,0,0,0,1,3'd5,0,0,0, 4'd7, 0, O_ENV);
        add(0,0,0,0,0,0,0,0,0,0, 4'd8, 0, O_NADA);
        add(0,0,0,0,0,0,0,0,1,1, 4'd9, 0, O_MUDA);
        add(0,0,0,0,0,0,0,0,0,0, 4'd10, 0, O_FECHA | O_DESL);
        add(0,0,0,0,0,0,0,0,0,0, 4'd11, 0, O_C2);
        add(0,0,1,0,0,0,0,0,0,0, 4'd12, 0, O_DESL | O_FECHA);
        add(0,0,0,0,0,0,0,0,0,0, 4'd0, 0, O_NADA);

        // Reset state
        cyc(); cyc();
        chk("reset_estado", 32'(db_estado), 32'd0);
        chk("reset_tent", 32'(db_tentativas), 32'd0);
        chk("reset_outs", 32'(outs), 32'd0);
        reset = 0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            ligar = vecs[i].ligar; fim_1s = vecs[i].f1; fim_2s = vecs[i].f2; fim_estado4 = vecs[i].f4;
            fim_medida = vecs[i].fmed; fim_classificacao = vecs[i].fcls;
            medida_classificacao = vecs[i].med; descartar_medida = vecs[i].desc;
            fim_carater = vecs[i].fcar; fim_mensagem = vecs[i].fmsg;
            cyc();
            chk($sformatf("vec%0d_estado", i), 32'(db_estado), 32'(vecs[i].e_est));
            chk($sformatf("vec%0d_tent", i), 32'(db_tentativas), 32'(vecs[i].e_tent));
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].e_out));
        end
        clear_inputs();

        // Three consecutive discards -> FALHA, then recovery through PREPARA
        ligar = 1; cyc(); cyc();
        chk("falha_start", 32'(db_estado), 32'd2);
        ate_classificacao(); descarta();
        chk("falha_t1_est", 32'(db_estado), 32'd2);
        chk("falha_t1", 32'(db_tentativas), 32'd1);
        ate_classificacao(); descarta();
        chk("falha_t2_est", 32'(db_estado), 32'd2);
        chk("falha_t2", 32'(db_tentativas), 32'd2);
        ate_classificacao(); descarta();
        chk("falha_estado", 32'(db_estado), 32'd13);
        chk("falha_t3", 32'(db_tentativas), 32'd3);
        chk("falha_strobes", 32'(outs), 32'(O_BZA | O_BZB | O_FECHA));
        cyc();
        chk("falha_espera", 32'(outs), 32'(O_C4));
        chk("falha_espera_est", 32'(db_estado), 32'd13);
        fim_estado4 = 1; cyc(); fim_estado4 = 0;
        chk("falha_prepara", 32'(db_estado), 32'd1);
        chk("falha_zera", 32'(outs), 32'(O_ZERA));
        cyc();
        chk("falha_pos_est", 32'(db_estado), 32'd2);
        chk("falha_pos_tent", 32'(db_tentativas), 32'd0);

        // Asynchronous reset in the middle of TRANSMITE
        ate_classificacao(); descarta();
        chk("rst_pre_tent", 32'(db_tentativas), 32'd1);
        ate_classificacao();
        fim_classificacao = 1; medida_classificacao = 3'd1; cyc(); clear_inputs();
        chk("rst_transmite", 32'(db_estado), 32'd7);
        #2 reset = 1;
        #1;
        chk("rst_async_est", 32'(db_estado), 32'd0);
        chk("rst_async_outs", 32'(outs), 32'd0);
        chk("rst_async_tent", 32'(db_tentativas), 32'd0);
        cyc();
        reset = 0;
        cyc();
        chk("rst_pos_est", 32'(db_estado), 32'd1);

        // Measurement timeout (or its absence)
        reset = 1; cyc(); reset = 0;
        ligar = 1; cyc(); cyc();
        fim_1s = 1; cyc(); fim_1s = 0; cyc();
        chk("wd_entrada", 32'(db_estado), 32'd4);
`ifdef UC_WATCHDOG_MEDIDA_EN
        n = 0;
        while (db_estado == 4'd4 && n < 100) begin
            n++;
            cyc();
        end
        chk("wd_ciclos", 32'(n), 32'd16);
        chk("wd_estado", 32'(db_estado), 32'd2);
        chk("wd_tent", 32'(db_tentativas), 32'd1);
`else
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (db_estado != 4'd4) n++;
        end
        chk("sem_wd_saidas", 32'(n), 32'd0);
        chk("sem_wd_estado", 32'(db_estado), 32'd4);
        chk("sem_wd_tent", 32'(db_tentativas), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uc_ciclo_medicao.md
Name: uc_ciclo_medicao

Overview:
- Control unit that sequences the level-monitor datapath through repeated cycles: wait, measure (3 sensors), classify, transmit the 4-character ASCII frame, then drive the buzzers and valve.
- Sits beside the datapath and drives its handshake inputs (zera, conta_1s, conta_2s, conta_estado4, mensurar, analisa_medida, envia, muda, buzzer and valve strobes).
- Retries discarded measurements and enters a fault state after repeated failures.

Parameters:
- MAX_TENTATIVAS, 3, consecutive discarded or timed-out measurements before FALHA (1..15).
- TIMEOUT_CICLOS, 3000000, watchdog limit in AGUARDA_MEDIDA (only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ligar  in  1  level; run cycles while high
- fim_1s, fim_2s, fim_estado4  in  1 each  datapath timer terminal counts
- fim_medida  in  1  sensor interface done (pulse)
- fim_classificacao  in  1  classifier done (pulse)
- medida_classificacao  in  3  0=NORMAL, 1=BAIXO, 2=CRITICO, 3=ALTO, others treated as NORMAL
- descartar_medida  in  1  valid with fim_classificacao
- fim_carater  in  1  serial TX character done
- fim_mensagem  in  1  character selector on last char
- zera, conta_1s, conta_2s, conta_estado4, mensurar, analisa_medida, envia, muda  out  1 each  datapath controls
- liga_buzzer_alta, liga_buzzer_baixa, desliga_buzzers, abre_valvula_auto, fecha_valvula_auto  out  1 each  actuator strobes
- db_estado  out  4  state code
- db_tentativas  out  4  retry counter

Behaviour:
- Registered state and counters. All outputs are Moore-decoded from state; actuator strobes are 1-cycle pulses.
- Reset: state INICIAL(0), tentativas=0, classe=0, ultimo=0; all outputs 0 except db_estado=0.
- INICIAL(0): idle. ligar=1 -> PREPARA.
- PREPARA(1): zera=1 for one cycle. tentativas:=0. -> ESPERA_1S.
- ESPERA_1S(2): conta_1s=1. fim_1s -> MEDE.
  - conta remains high on the exit cycle so the timer wraps to 0.
- MEDE(3): mensurar=1 for one cycle. -> AGUARDA_MEDIDA.
- AGUARDA_MEDIDA(4): fim_medida -> CLASSIFICA.
- CLASSIFICA(5): analisa_medida=1 for one cycle. -> AGUARDA_CLASS.
- AGUARDA_CLASS(6): on fim_classificacao:
  - If descartar_medida: tentativas++. If the new value equals MAX_TENTATIVAS -> FALHA, else -> ESPERA_1S.
  - Otherwise: latch classe, tentativas:=0 -> TRANSMITE.
- TRANSMITE(7): envia=1 for one cycle. -> AGUARDA_CARATER.
- AGUARDA_CARATER(8): fim_carater -> PROX_CARATER, with ultimo:=fim_mensagem.
- PROX_CARATER(9): muda=1. ultimo ? ATUA : TRANSMITE.
  - Exactly 4 envia pulses per frame; the selector is left at 0.
- ATUA(10): one-cycle strobes by classe:
  - CRITICO: abre_valvula_auto, liga_buzzer_baixa.
  - BAIXO: liga_buzzer_baixa.
  - ALTO: fecha_valvula_auto, liga_buzzer_alta.
  - NORMAL: fecha_valvula_auto, desliga_buzzers.
  - -> ESPERA_2S.
- ESPERA_2S(11): conta_2s=1. On fim_2s: ligar ? ESPERA_1S : DESLIGA.
- DESLIGA(12): desliga_buzzers=1, fecha_valvula_auto=1. -> INICIAL.
- FALHA(13): one-cycle liga_buzzer_alta+liga_buzzer_baixa+fecha_valvula_auto on entry, then conta_estado4=1. On fim_estado4 -> PREPARA.
- ligar=0 is only sampled in INICIAL and ESPERA_2S; an active cycle always completes.
- Simultaneous fim_* inputs are ignored unless the current state waits on them.
- Reset mid-operation returns to INICIAL immediately, asynchronously. Unused codes 14-15 -> INICIAL.
- tentativas saturates logic at MAX_TENTATIVAS and never wraps.

Optional Feature:
- UC_WATCHDOG_MEDIDA_EN defined: a 22-bit counter clears on entry to AGUARDA_MEDIDA and increments each cycle there.
  - Reaching TIMEOUT_CICLOS-1 without fim_medida is treated exactly as descartar_medida (tentativas++, retry or FALHA).
  - fim_medida in the same cycle wins.
- Undefined: no counter; AGUARDA_MEDIDA waits indefinitely.

Decomposition:
- Shared package: state encoding constants (0..13) and classification codes (NORMAL/BAIXO/CRITICO/ALTO). The datapath classifier uses the same codes.
- One sub-module is natural: uc_watchdog (clear/enable/expired), instantiated only under the macro.

Test Plan:
- Reset mid-TRANSMITE -> next cycle db_estado=0, all strobes 0, db_tentativas=0.
- ligar=1, fim_medida after 5 cycles, class=2 no discard -> exactly 4 envia pulses, 4 muda pulses, then one abre_valvula_auto + liga_buzzer_baixa pulse, then db_estado=11.
- MAX_TENTATIVAS=3, descartar_medida on 3 consecutive classifications -> db_tentativas 1,2 then FALHA(13); buzzers both strobed once; after fim_estado4 -> PREPARA with zera pulse.
- Two discards then a valid class=3 -> db_tentativas returns to 0; fecha_valvula_auto + liga_buzzer_alta pulse.
- ligar dropped during AGUARDA_CARATER -> frame completes; after fim_2s -> DESLIGA with desliga_buzzers + fecha pulse -> INICIAL.
- UC_WATCHDOG_MEDIDA_EN, TIMEOUT_CICLOS=16, no fim_medida -> after 16 cycles in state 4, db_tentativas=1 and state 2; without the macro, still in state 4 after 1000 cycles.
